matmul2x2_ctrl: RTL

//   Sequencer that computes a 2x2 matrix product C = A x B on one shared two-term dot-product ALU.

---
 rtl/matmul2x2_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/matmul2x2_ctrl.sv
// matmul2x2_ctrl: sequences C = A x B as four jobs on a shared dot-product ALU.
// Optional MATMUL_TIMEOUT_EN adds a per-job WAIT timeout with a sticky err flag.
module matmul2x2_ctrl #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 18
`ifdef MATMUL_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a00,
    input  logic [DATA_W-1:0] a01,
    input  logic [DATA_W-1:0] a10,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] b00,
    input  logic [DATA_W-1:0] b01,
    input  logic [DATA_W-1:0] b10,
    input  logic [DATA_W-1:0] b11,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [RES_W-1:0]  c00,
    output logic [RES_W-1:0]  c01,
    output logic [RES_W-1:0]  c10,
    output logic [RES_W-1:0]  c11,
    output logic              alu_start,
    output logic [DATA_W-1:0] alu_row0,
    output logic [DATA_W-1:0] alu_row1,
    output logic [DATA_W-1:0] alu_col0,
    output logic [DATA_W-1:0] alu_col1,
    input  logic              alu_complete,
    input  logic [RES_W-1:0]  alu_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_idx;
    logic [1:0]        w_nidx;
    logic [DATA_W-1:0] r_a [4];
    logic [DATA_W-1:0] r_b [4];
    logic [DATA_W-1:0] w_a [4];
    logic [DATA_W-1:0] w_b [4];
    logic [RES_W-1:0]  r_c [4];
    logic [DATA_W-1:0] r_row0;
    logic [DATA_W-1:0] r_row1;
    logic [DATA_W-1:0] r_col0;
    logic [DATA_W-1:0] r_col1;
    logic              w_accept;
    logic              w_complete;
    logic              w_load;
    logic              w_tmo;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_complete = (r_state == S_WAIT) && alu_complete;
    assign w_load     = w_accept || (w_complete && (r_idx != 2'd3));
    assign w_nidx     = w_accept ? 2'd0 : r_idx + 2'd1;

    // On accept the operands come straight from the ports, so ISSUE
    // already sees the first job's operands in its first cycle.
    always_comb begin
        w_a = r_a;
        w_b = r_b;
        if (w_accept) begin
            w_a[0] = a00;
            w_a[1] = a01;
            w_a[2] = a10;
            w_a[3] = a11;
            w_b[0] = b00;
            w_b[1] = b01;
            w_b[2] = b10;
            w_b[3] = b11;
        end
    end

`ifdef MATMUL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_tmo = (r_state == S_WAIT) && !alu_complete
                && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT) && !alu_complete) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (alu_complete) begin
                    w_next = (r_idx == 2'd3) ? S_DONE : S_ISSUE;
                end else if (w_tmo) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= 2'd0;
            r_row0 <= '0;
            r_row1 <= '0;
            r_col0 <= '0;
            r_col1 <= '0;
            for (int k = 0; k < 4; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_c[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_a <= w_a;
                r_b <= w_b;
            end
            // Element index is {row, col}: row from idx[1], col from idx[0].
            if (w_load) begin
                r_idx  <= w_nidx;
                r_row0 <= w_a[{w_nidx[1], 1'b0}];
                r_row1 <= w_a[{w_nidx[1], 1'b1}];
                r_col0 <= w_b[{1'b0, w_nidx[0]}];
                r_col1 <= w_b[{1'b1, w_nidx[0]}];
            end
            if (w_complete) begin
                r_c[r_idx] <= alu_out;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign alu_start = (r_state == S_ISSUE);
    assign alu_row0  = r_row0;
    assign alu_row1  = r_row1;
    assign alu_col0  = r_col0;
    assign alu_col1  = r_col1;
    assign c00       = r_c[0];
    assign c01       = r_c[1];
    assign c10       = r_c[2];
    assign c11       = r_c[3];

endmodule
